// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone memory responder.
//   state_t    : controller states
//   sel_legal  : byte-select legality for a given data width
//   init_byte  : self-initialisation pattern (byte address mod 256)
package wb_resp_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Only naturally aligned single bytes, aligned half-words and full words
  // are accepted; sel is zero-extended to 4 bits by the caller.
  function automatic logic sel_legal(input int dw, input logic [3:0] sel);
    logic ok;
    case (dw)
      32: begin
        case (sel)
          4'b0001, 4'b0010, 4'b0100, 4'b1000,
          4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
          default:                   ok = 1'b0;
        endcase
      end
      16:      ok = (sel == 4'b0001) || (sel == 4'b0010) || (sel == 4'b0011);
      8:       ok = (sel == 4'b0001);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lane b of word w holds the low byte of its own byte address.
  function automatic logic [7:0] init_byte(input int word, input int lane, input int dw);
    return 8'((word * (dw / 8) + lane) % 256);
  endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone classic bus bundle between an initiator and the memory responder.
//   master modport : drives cyc/stb/we/adr/sel/dat_i, receives dat_o/ack/err
//   slave modport  : the mirror image, used by wb_mem_responder
interface wb_mem_responder_if #(
  parameter int DW = 32
);
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [31:0]     wb_adr_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_resp_ram.sv
// Single-port RAM with per-byte-lane write enables and registered read.
//   clk   : clock
//   addr  : word address (shared by read and write)
//   we    : one write enable per byte lane
//   wdata : write data
//   rdata : data at addr, registered (old contents on a same-cycle write)
module wb_resp_ram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] we,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [2**AW];

  // Lane-masked write and synchronous read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave backed by a self-initialising word RAM.
//   wb_clk_i    : clock
//   wb_rst_i    : asynchronous active-high reset; restarts initialisation
//   bus         : Wishbone slave bundle (cyc/stb/we/adr/sel/dat in, dat/ack/err out)
//   init_done_o : high once every word holds its byte-address pattern
// Requests are accepted in IDLE, optionally delayed by WAIT_STATES cycles
// (aborted if cyc/stb drop), and terminated with ack or, for illegal byte
// selects, err (ack without write when ERR_EN=0).
module wb_mem_responder
  import wb_resp_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 6,
  parameter int WAIT_STATES = 1,
  parameter int ERR_EN      = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_mem_responder_if.slave  bus,
  output logic               init_done_o
);
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);

  state_t          state, state_n;
  logic [AW-1:0]   init_cnt, init_cnt_n;
  logic [3:0]      wait_cnt, wait_cnt_n;
  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [NB-1:0]   sel_q;
  logic [DW-1:0]   dat_q;
  logic            ack, err, ack_n, err_n;
  logic [DW-1:0]   dat_out;
  logic            done_n, latch, load_rd, legal;
  logic [AW-1:0]   bus_idx, ram_addr;
  logic [NB-1:0]   ram_we;
  logic [DW-1:0]   ram_wdata, ram_rdata, init_word;

  // Word index wraps modulo the memory depth; upper address bits are ignored.
  assign bus_idx = AW'(bus.wb_adr_i >> LSB);

  assign bus.wb_ack_o = ack;
  assign bus.wb_err_o = err;
  assign bus.wb_dat_o = dat_out;

  // Pattern word written during initialisation.
  always_comb begin
    init_word = '0;
    for (int b = 0; b < NB; b++) begin
      init_word[8*b +: 8] = init_byte(int'(init_cnt), b, DW);
    end
  end

  // Next-state, RAM port steering and termination decode.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    wait_cnt_n = wait_cnt;
    ram_addr   = adr_q;
    ram_we     = '0;
    ram_wdata  = dat_q;
    ack_n      = 1'b0;
    err_n      = 1'b0;
    load_rd    = 1'b0;
    latch      = 1'b0;
    done_n     = init_done_o;
    legal      = sel_legal(DW, 4'(sel_q));
    case (state)
      INIT: begin
        ram_addr  = init_cnt;
        ram_we    = '1;
        ram_wdata = init_word;
        if (init_cnt == '1) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          init_cnt_n = init_cnt + AW'(1);
        end
      end
      IDLE: begin
        // Address the RAM from the live bus so read data is ready one
        // cycle after the sample edge even with zero wait states.
        ram_addr   = bus_idx;
        wait_cnt_n = 4'd0;
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          latch   = 1'b1;
          state_n = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (!(bus.wb_cyc_i && bus.wb_stb_i)) begin
          state_n = IDLE;
        end else if (wait_cnt == 4'(WAIT_STATES - 1)) begin
          state_n = RESP;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
        if (legal) begin
          ack_n = 1'b1;
          if (we_q) begin
            ram_we = sel_q;
          end else begin
            load_rd = 1'b1;
          end
        end else begin
          ack_n = (ERR_EN == 0);
          err_n = (ERR_EN != 0);
        end
      end
      default: state_n = INIT;
    endcase
  end

  // State, request capture and registered bus outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= INIT;
      init_cnt    <= '0;
      wait_cnt    <= 4'd0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      dat_out     <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= state_n;
      init_cnt    <= init_cnt_n;
      wait_cnt    <= wait_cnt_n;
      ack         <= ack_n;
      err         <= err_n;
      init_done_o <= done_n;
      if (latch) begin
        adr_q <= bus_idx;
        we_q  <= bus.wb_we_i;
        sel_q <= bus.wb_sel_i;
        dat_q <= bus.wb_dat_i;
      end
      if (load_rd) begin
        dat_out <= ram_rdata;
      end
    end
  end

  wb_resp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (wb_clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench for wb_mem_responder. Three instances share clock/reset:
//   dut0 : DW=32, WAIT_STATES=1, ERR_EN=1
//   dut1 : DW=16, WAIT_STATES=0, ERR_EN=1
//   dut2 : DW=32, WAIT_STATES=3, ERR_EN=0
// The driver pushes the expected termination (ack/err, dat_o, cycle) into a
// per-instance queue; a negedge monitor pops and compares.
module tb_wb_mem_responder;

  localparam int NBA[3] = '{4, 2, 4};
  localparam int WSA[3] = '{1, 0, 3};
  localparam int ERA[3] = '{1, 1, 0};

  typedef struct {
    logic [1:0]  term;   // {ack, err}
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done0, done1, done2;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t        q[3][$];
  logic [31:0] mem_m[3][64];
  logic [31:0] last_rd[3];

  wb_mem_responder_if #(.DW(32)) if0 ();
  wb_mem_responder_if #(.DW(16)) if1 ();
  wb_mem_responder_if #(.DW(32)) if2 ();

  wb_mem_responder #(.DW(32), .AW(6), .WAIT_STATES(1), .ERR_EN(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if0), .init_done_o(done0));
  wb_mem_responder #(.DW(16), .AW(6), .WAIT_STATES(0), .ERR_EN(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if1), .init_done_o(done1));
  wb_mem_responder #(.DW(32), .AW(6), .WAIT_STATES(3), .ERR_EN(0)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if2), .init_done_o(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h required %h", nm, id, act, exp);
  endtask

  // Reference model: every byte holds its byte address mod 256.
  task automatic init_model();
    for (int id = 0; id < 3; id++) begin
      last_rd[id] = 32'h0;
      for (int w = 0; w < 64; w++) begin
        mem_m[id][w] = 32'h0;
        for (int b = 0; b < NBA[id]; b++) mem_m[id][w][8*b +: 8] = 8'((w * NBA[id] + b) % 256);
      end
    end
  endtask

  // Legal = a non-empty, naturally aligned block of 1, 2 or 4 lanes.
  function automatic bit sel_ok(input int id, input logic [3:0] sel);
    int n;
    int nb;
    n  = $countones(sel);
    nb = NBA[id];
    if (sel == 4'h0 || n > nb) return 1'b0;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    for (int k = 0; k * n < nb; k++) begin
      if (32'(sel) == (((32'd1 << n) - 32'd1) << (k * n))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int widx(input int id, input logic [31:0] adr);
    int sh;
    sh = (NBA[id] == 4) ? 2 : ((NBA[id] == 2) ? 1 : 0);
    return int'((adr >> sh) & 32'h3f);
  endfunction

  function automatic logic [1:0] get_term(input int id);
    case (id)
      0:       return {if0.wb_ack_o, if0.wb_err_o};
      1:       return {if1.wb_ack_o, if1.wb_err_o};
      default: return {if2.wb_ack_o, if2.wb_err_o};
    endcase
  endfunction

  function automatic logic [31:0] get_dat(input int id);
    case (id)
      0:       return if0.wb_dat_o;
      1:       return {16'h0, if1.wb_dat_o};
      default: return if2.wb_dat_o;
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic drive(input int id, input bit act, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    case (id)
      0: begin
        if0.wb_cyc_i = act; if0.wb_stb_i = act; if0.wb_we_i = we;
        if0.wb_adr_i = adr; if0.wb_sel_i = sel; if0.wb_dat_i = dat;
      end
      1: begin
        if1.wb_cyc_i = act; if1.wb_stb_i = act; if1.wb_we_i = we;
        if1.wb_adr_i = adr; if1.wb_sel_i = sel[1:0]; if1.wb_dat_i = dat[15:0];
      end
      default: begin
        if2.wb_cyc_i = act; if2.wb_stb_i = act; if2.wb_we_i = we;
        if2.wb_adr_i = adr; if2.wb_sel_i = sel; if2.wb_dat_i = dat;
      end
    endcase
  endtask

  // One transfer. With b2b set the request is raised in the same negedge
  // that saw the previous termination, so stb never drops in between.
  task automatic xfer(input int id, input bit we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat, input bit b2b);
    exp_t e;
    int   w;
    int   k;
    bit   legal;
    if (!b2b) @(negedge clk);
    w     = widx(id, adr);
    legal = sel_ok(id, sel);
    e.term = (legal || ERA[id] == 0) ? 2'b10 : 2'b01;
    if (legal && !we) last_rd[id] = mem_m[id][w];
    if (legal && we) begin
      for (int b = 0; b < NBA[id]; b++) if (sel[b]) mem_m[id][w][8*b +: 8] = dat[8*b +: 8];
    end
    e.dat = last_rd[id];
    e.cyc = cycle + WSA[id] + 2;
    q[id].push_back(e);
    drive(id, 1'b1, we, adr, sel, dat);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (get_term(id) != 2'b00 || k >= 40) break;
    end
    if (get_term(id) == 2'b00) begin
      n_checks++;
      $display("FAIL timeout dut%0d: no ack/err after %0d cycles, required one", id, k);
      void'(q[id].pop_back());
    end
    drive(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [1:0] t;
    if (!rst) begin
      for (int id = 0; id < 3; id++) begin
        t = get_term(id);
        if (t != 2'b00) begin
          if (q[id].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_term dut%0d: got ack/err=%b required none", id, t);
          end else begin
            e = q[id].pop_front();
            chk("ack_err", id, 32'(t), 32'(e.term));
            chk("dat_o", id, get_dat(id), e.dat);
            chk("latency", id, cycle, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int bound;
    bit all_done;
    for (int id = 0; id < 3; id++) drive(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    init_model();
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk("rst_term", id, 32'(get_term(id)), 32'h0);
      chk("rst_dat", id, get_dat(id), 32'h0);
      chk("rst_done", id, 32'(get_done(id)), 32'h0);
    end

    // Initialisation: requests are ignored, done rises after 64 cycles.
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 32'h4, 4'h3, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 20) drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      if (k == 63) for (int id = 0; id < 3; id++) chk("done_early", id, 32'(get_done(id)), 32'h0);
      if (k == 64) for (int id = 0; id < 3; id++) chk("done", id, 32'(get_done(id)), 32'h1);
    end

    // 32-bit, one wait state.
    xfer(0, 1'b0, 32'h0, 4'hf, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h4, 4'hf, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'hc, 4'hf, 32'h0, 1'b1);
    xfer(0, 1'b1, 32'h10, 4'hf, 32'habbabeef, 1'b0);
    xfer(0, 1'b1, 32'h10, 4'h2, 32'h00001100, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'h1, 32'h0, 1'b1);
    xfer(0, 1'b1, 32'h20, 4'h6, 32'h00baad00, 1'b0);
    xfer(0, 1'b0, 32'h20, 4'hf, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h104, 4'hf, 32'h0, 1'b1);
    // 16-bit, zero wait states.
    xfer(1, 1'b1, 32'h2, 4'h3, 32'h00000ab1, 1'b0);
    xfer(1, 1'b0, 32'h2, 4'h3, 32'h0, 1'b1);
    xfer(1, 1'b1, 32'h4, 4'h3, 32'h00004ef5, 1'b0);
    xfer(1, 1'b0, 32'h4, 4'h1, 32'h0, 1'b0);
    xfer(1, 1'b1, 32'h6, 4'h0, 32'h0000ffff, 1'b0);
    xfer(1, 1'b0, 32'h6, 4'h3, 32'h0, 1'b0);
    // Three wait states, illegal sel acked without write.
    xfer(2, 1'b1, 32'h8, 4'h5, 32'h12345678, 1'b0);
    xfer(2, 1'b0, 32'h8, 4'hf, 32'h0, 1'b0);

    // Abort after one wait cycle: no termination, no write.
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'h8, 4'hf, 32'hdeadbeef);
    repeat (2) @(negedge clk);
    if2.wb_stb_i = 1'b0;
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (8) @(negedge clk);
    xfer(2, 1'b0, 32'h8, 4'hf, 32'h0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 150; i++) begin
      int          id;
      logic [3:0]  sel;
      id  = $urandom_range(0, 2);
      sel = (id == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      xfer(id, 1'($urandom_range(0, 1)), $urandom, sel, $urandom, (i != 0) && ($urandom_range(0, 1) == 1));
    end

    // Reset during a wait cycle.
    xfer(0, 1'b0, 32'h4, 4'hf, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 4'hf, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_term", 0, 32'(get_term(0)), 32'h0);
    chk("rst_mid_dat", 0, get_dat(0), 32'h0);
    for (int id = 0; id < 3; id++) chk("rst_mid_done", id, 32'(get_done(id)), 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    init_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h10, 4'hf, 32'h55555555);
    drive(2, 1'b1, 1'b0, 32'h8, 4'hf, 32'h0);
    repeat (10) @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    bound = 0;
    all_done = 1'b0;
    while (!all_done && bound < 200) begin
      @(negedge clk);
      bound++;
      all_done = done0 && done1 && done2;
    end
    chk("reinit_done", 0, 32'(all_done), 32'h1);
    xfer(0, 1'b0, 32'h10, 4'hf, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h20, 4'hf, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h2, 4'h3, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h4, 4'h3, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h8, 4'hf, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    for (int id = 0; id < 3; id++) chk("pending", id, 32'(q[id].size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
